sobel_pipe_kernel: RTL and testbench

//  Pipelined, parametrised successor of the single-cycle 3x3 Sobel kernel.

---
 rtl/sobel_pipe_kernel_if.sv | 29 ++
 rtl/sobel_pipe_kernel.sv | 114 +++++++++++
 tb/tb_sobel_pipe_kernel.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sobel_pipe_kernel_if.sv
// Stream bundle between the window generator, the Sobel kernel and the pixel writer.
// The kernel connects through the slave modport and its driver through the master modport.
interface sobel_pipe_kernel_if #(
  parameter int PIX_W = 8
);
  localparam int MAG_W = 2 * PIX_W + 6;

  logic                 in_valid;
  logic                 in_ready;
  logic [8*PIX_W-1:0]   in_win;
  logic [1:0]           mode;
  logic [MAG_W-1:0]     thr_sq;
  logic [PIX_W+2:0]     thr_l1;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_edge;
  logic [PIX_W-1:0]     out_pix;
  logic [1:0]           out_dir;

  modport master (
    output in_valid, in_win, mode, thr_sq, thr_l1, out_ready,
    input  in_ready, out_valid, out_edge, out_pix, out_dir
  );

  modport slave (
    input  in_valid, in_win, mode, thr_sq, thr_l1, out_ready,
    output in_ready, out_valid, out_edge, out_pix, out_dir
  );
endinterface

// File: rtl/sobel_pipe_kernel.sv
// Three-stage pipelined 3x3 Sobel kernel: gradients, metrics/direction, then
// threshold/select into registered outputs, all stalling together under backpressure.
module sobel_pipe_kernel #(
  parameter int PIX_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  sobel_pipe_kernel_if.slave bus
);
  localparam int GW    = PIX_W + 3;
  localparam int MAG_W = 2 * PIX_W + 6;
  localparam int L1_W  = PIX_W + 4;

  logic adv;
  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  // Neighbours zero-extended into the signed gradient width.
  logic signed [GW-1:0] px [8];
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_unpack
      assign px[gi] = $signed({3'b000, bus.in_win[gi*PIX_W +: PIX_W]});
    end
  endgenerate

  logic signed [GW-1:0] gx_next, gy_next;
  assign gx_next = (px[2] + px[4] + px[4] + px[7]) - (px[0] + px[3] + px[3] + px[5]);
  assign gy_next = (px[5] + px[6] + px[6] + px[7]) - (px[0] + px[1] + px[1] + px[2]);

  logic                 s1_valid;
  logic signed [GW-1:0] s1_gx, s1_gy;
  logic [1:0]           s1_mode;
  logic [MAG_W-1:0]     s1_thr_sq;
  logic [PIX_W+2:0]     s1_thr_l1;

  logic                 s2_valid;
  logic [MAG_W-1:0]     s2_sq;
  logic [L1_W-1:0]      s2_l1;
  logic [1:0]           s2_dir;
  logic [1:0]           s2_mode;
  logic [MAG_W-1:0]     s2_thr_sq;
  logic [PIX_W+2:0]     s2_thr_l1;

  logic                 out_valid_reg;
  logic                 out_edge_reg;
  logic [PIX_W-1:0]     out_pix_reg;
  logic [1:0]           out_dir_reg;

  logic [GW-1:0]        ax, ay;
  logic [MAG_W-1:0]     sq_next;
  logic [L1_W-1:0]      l1_next;
  logic [1:0]           dir_next;
  logic                 edge_next;
  logic [PIX_W-1:0]     sat_l1;
  logic [PIX_W-1:0]     pix_next;

  always_comb begin
    ax       = s1_gx[GW-1] ? -s1_gx : s1_gx;
    ay       = s1_gy[GW-1] ? -s1_gy : s1_gy;
    sq_next  = MAG_W'(ax) * MAG_W'(ax) + MAG_W'(ay) * MAG_W'(ay);
    l1_next  = L1_W'(ax) + L1_W'(ay);
    // Ties go to Gx, so a zero gradient yields 2'b00.
    dir_next = (ay > ax) ? {1'b1, s1_gy[GW-1]} : {1'b0, s1_gx[GW-1]};
  end

  always_comb begin
    if (s2_mode == 2'd1 || s2_mode == 2'd2) begin
      edge_next = (s2_l1 >= L1_W'(s2_thr_l1));
    end else begin
      edge_next = (s2_sq >= s2_thr_sq);
    end
    sat_l1   = (|s2_l1[L1_W-1:PIX_W]) ? {PIX_W{1'b1}} : s2_l1[PIX_W-1:0];
    pix_next = (s2_mode == 2'd2) ? sat_l1 : {PIX_W{edge_next}};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid      <= 1'b0;
      s2_valid      <= 1'b0;
      out_valid_reg <= 1'b0;
      out_edge_reg  <= 1'b0;
      out_pix_reg   <= '0;
      out_dir_reg   <= '0;
    end else if (adv) begin
      s1_valid      <= bus.in_valid;
      s1_gx         <= gx_next;
      s1_gy         <= gy_next;
      s1_mode       <= bus.mode;
      s1_thr_sq     <= bus.thr_sq;
      s1_thr_l1     <= bus.thr_l1;

      s2_valid      <= s1_valid;
      s2_sq         <= sq_next;
      s2_l1         <= l1_next;
      s2_dir        <= dir_next;
      s2_mode       <= s1_mode;
      s2_thr_sq     <= s1_thr_sq;
      s2_thr_l1     <= s1_thr_l1;

      out_valid_reg <= s2_valid;
      if (s2_valid) begin
        out_edge_reg <= edge_next;
        out_pix_reg  <= pix_next;
        out_dir_reg  <= s2_dir;
      end
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_edge  = out_edge_reg;
  assign bus.out_pix   = out_pix_reg;
  assign bus.out_dir   = out_dir_reg;
endmodule

// File: tb/tb_sobel_pipe_kernel.sv
// Bench for the pipelined Sobel kernel: directed corner cases, a stalled burst,
// a mid-stream reset and a randomized stream scored against an arithmetic model.
module tb_sobel_pipe_kernel;
  localparam int PIX_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sobel_pipe_kernel_if #(.PIX_W(PIX_W)) bus ();
  sobel_pipe_kernel #(.PIX_W(PIX_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic       e;
    logic [7:0] pix;
    logic [1:0] dir;
    int         acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   lat_check = 1'b0;
  bit   use_const = 1'b0;
  exp_t const_exp;
  bit   hold_prev = 1'b0;
  int   held = 0;

  function automatic exp_t model(input logic [63:0] win, input logic [1:0] md,
                                 input int tsq, input int tl1);
    exp_t r;
    int p[8];
    int gx, gy, ax, ay, sq, l1, m;
    for (int i = 0; i < 8; i++) p[i] = int'(win[i*8 +: 8]);
    gx = p[2] + 2 * p[4] + p[7] - p[0] - 2 * p[3] - p[5];
    gy = p[5] + 2 * p[6] + p[7] - p[0] - 2 * p[1] - p[2];
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    sq = ax * ax + ay * ay;
    l1 = ax + ay;
    m  = (md == 2'd3) ? 0 : int'(md);
    r.e   = (m == 0) ? (sq >= tsq) : (l1 >= tl1);
    r.pix = (m == 2) ? 8'((l1 > 255) ? 255 : l1) : (r.e ? 8'hFF : 8'h00);
    if (ay > ax) r.dir = {1'b1, gy < 0};
    else         r.dir = {1'b0, gx < 0};
    r.acc_cyc = 0;
    return r;
  endfunction

  function automatic logic [63:0] pack8(input int p0, input int p1, input int p2, input int p3,
                                        input int p4, input int p5, input int p6, input int p7);
    return {8'(p7), 8'(p6), 8'(p5), 8'(p4), 8'(p3), 8'(p2), 8'(p1), 8'(p0)};
  endfunction

  task automatic chk(input string tag, input int obs, input int expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // One clock cycle: sample at the falling edge, score, then step past the rising edge.
  task automatic tick(output bit acc);
    exp_t e;
    @(negedge clk);
    acc = 1'b0;
    if (rst_n) begin
      chk("in_ready", int'(bus.in_ready), int'(!bus.out_valid || bus.out_ready));
      if (hold_prev) begin
        chk("hold_valid", int'(bus.out_valid), 1);
        chk("hold_data", int'({bus.out_edge, bus.out_pix, bus.out_dir}), held);
      end
      hold_prev = bus.out_valid && !bus.out_ready;
      if (hold_prev) held = int'({bus.out_edge, bus.out_pix, bus.out_dir});
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("stale_out", int'(bus.out_valid), 0);
        end else begin
          e = sb.pop_front();
          chk("out_edge", int'(bus.out_edge), int'(e.e));
          chk("out_pix", int'(bus.out_pix), int'(e.pix));
          chk("out_dir", int'(bus.out_dir), int'(e.dir));
          if (lat_check) chk("latency", cyc - e.acc_cyc, 3);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        acc = 1'b1;
        e = use_const ? const_exp
                      : model(bus.in_win, bus.mode, int'(bus.thr_sq), int'(bus.thr_l1));
        e.acc_cyc = cyc;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_n) begin
      sb.delete();
      hold_prev = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    bit a;
    bus.in_valid = 1'b0;
    repeat (n) tick(a);
  endtask

  task automatic drain();
    bit a;
    int k = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while (sb.size() > 0 && k < 40) begin
      tick(a);
      k++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic send_dir(input logic [63:0] win, input logic [1:0] md, input int tsq,
                          input int tl1, input logic e, input int px, input logic [1:0] d);
    bit a;
    bus.in_win    = win;
    bus.mode      = md;
    bus.thr_sq    = 22'(tsq);
    bus.thr_l1    = 11'(tl1);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    const_exp.e   = e;
    const_exp.pix = 8'(px);
    const_exp.dir = d;
    use_const     = 1'b1;
    lat_check     = 1'b1;
    tick(a);
    use_const     = 1'b0;
    chk("accept", int'(a), 1);
    drain();
  endtask

  task automatic rand_inputs();
    logic [63:0] w;
    int base;
    if ($urandom_range(0, 1) == 0) begin
      base = int'($urandom_range(0, 200));
      for (int i = 0; i < 8; i++) w[i*8 +: 8] = 8'(base + int'($urandom_range(0, 40)));
    end else begin
      for (int i = 0; i < 8; i++) w[i*8 +: 8] = 8'($urandom_range(0, 255));
    end
    bus.in_win = w;
    bus.mode   = 2'($urandom_range(0, 3));
    bus.thr_sq = 22'($urandom_range(0, 200000));
    bus.thr_l1 = 11'($urandom_range(0, 700));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] vstep;
    bit a;
    int idx;
    int c;

    bus.in_valid  = 1'b0;
    bus.in_win    = '0;
    bus.mode      = 2'd0;
    bus.thr_sq    = '0;
    bus.thr_l1    = '0;
    bus.out_ready = 1'b1;

    // Reset state
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_edge", int'(bus.out_edge), 0);
    chk("rst_out_pix", int'(bus.out_pix), 0);
    chk("rst_out_dir", int'(bus.out_dir), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);

    // Directed windows with spec-derived expectations
    send_dir(pack8(100, 100, 100, 100, 100, 100, 100, 100), 2'd0, 2500, 50, 1'b0, 0, 2'b00);
    vstep = pack8(0, 128, 255, 0, 255, 0, 128, 255);
    send_dir(vstep, 2'd0, 2500, 50, 1'b1, 255, 2'b00);
    send_dir(vstep, 2'd2, 2500, 50, 1'b1, 255, 2'b00);
    send_dir(pack8(0, 0, 0, 0, 25, 0, 0, 0), 2'd0, 2500, 0, 1'b1, 255, 2'b00);
    send_dir(pack8(0, 0, 0, 0, 24, 0, 0, 0), 2'd0, 2500, 0, 1'b0, 0, 2'b00);
    send_dir(pack8(0, 0, 0, 0, 25, 0, 0, 0), 2'd1, 4000000, 50, 1'b1, 255, 2'b00);
    send_dir(pack8(0, 0, 0, 0, 24, 0, 0, 0), 2'd3, 2500, 0, 1'b0, 0, 2'b00);
    send_dir(pack8(0, 0, 0, 0, 25, 0, 0, 0), 2'd2, 0, 60, 1'b0, 50, 2'b00);
    send_dir(pack8(0, 0, 0, 0, 0, 0, 255, 0), 2'd0, 2500, 0, 1'b1, 255, 2'b10);
    send_dir(pack8(0, 255, 0, 0, 0, 0, 0, 0), 2'd0, 2500, 0, 1'b1, 255, 2'b11);
    send_dir(pack8(0, 0, 0, 255, 0, 0, 0, 0), 2'd0, 2500, 0, 1'b1, 255, 2'b01);

    // Back-to-back burst of 8 with out_ready pattern 1,0,0,1
    lat_check = 1'b0;
    idx = 0;
    c = 0;
    while (idx < 8 && c < 100) begin
      rand_inputs();
      bus.in_valid  = 1'b1;
      bus.out_ready = (c % 4 == 0) || (c % 4 == 3);
      tick(a);
      while (!a && c < 100) begin
        c++;
        bus.out_ready = (c % 4 == 0) || (c % 4 == 3);
        tick(a);
      end
      idx++;
      c++;
    end
    chk("burst_accepted", idx, 8);
    drain();

    // Reset with three windows in flight
    lat_check = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) begin
      rand_inputs();
      bus.in_valid = 1'b1;
      tick(a);
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    tick(a);
    rst_n = 1'b1;
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    chk("midrst_in_ready", int'(bus.in_ready), 1);
    idle(6);
    send_dir(vstep, 2'd0, 2500, 50, 1'b1, 255, 2'b00);

    // Randomized stream with random backpressure
    lat_check = 1'b0;
    repeat (400) begin
      rand_inputs();
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.out_ready = ($urandom_range(0, 9) < 6);
      tick(a);
    end
    drain();
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
